id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the 5-stage core, sitting directly upstream of the ALU execute stage. Latches decoded operands and control each cycle, bubbles on flush or load-use hazard, and drives the forwarding selects (`SEL_A`/`SEL_B`, encoding 00 = register, 01 = writeback, 10 = ALU/EX-MEM result) plus `ALUsrc`/`ALUop` that the ALU top consumes. It also bypasses same-cycle writeback data into the operands captured from ID.

## Interface
- `XLEN`, 32, datapath width
- `RW`, 5, register index width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `flush` in 1: squash the instruction entering EX (branch/jump redirect)
- `hold` in 1: freeze the whole stage (external memory stall)
- `id_valid` in 1: ID holds a real instruction
- `id_A`, `id_B`, `id_immediate` in XLEN: register-file read data and immediate
- `id_rs1`, `id_rs2`, `id_rd` in RW
- `id_ALUop` in 4; `id_ALUsrc`, `id_RegWrite`, `id_MemRead`, `id_MemWrite` in 1
- `exmem_rd` in RW; `exmem_RegWrite` in 1
- `memwb_rd` in RW; `memwb_RegWrite` in 1; `wb_data` in XLEN
- `A`, `B`, `immediate` out XLEN: registered operands to the ALU
- `ALUop` out 4; `ALUsrc` out 1: registered
- `SEL_A`, `SEL_B` out 2: combinational forwarding selects
- `ex_rd` out RW; `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite` out 1: registered
- `stall_id` out 1: combinational; IF/ID must hold when high

## Operation
- Register update priority on each rising edge: `reset` > `flush` > `hold` > load-use bubble > normal load.
- Bubble (flush or load-use): `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite` = 0; `ALUop` = 4'b0000; `ex_rd` = 0. Operand registers are don't-care but are cleared to 0.
- `hold`: all registers keep their values. `flush` with `hold` flushes.
- Normal load: every EX register takes the corresponding `id_*` value; `ex_rs1`/`ex_rs2` are stored internally.
- WB bypass at capture: if `memwb_RegWrite` and `memwb_rd` != 0 and `memwb_rd` == `id_rs1`, then `A` captures `wb_data`, not `id_A`. Same for `B` with `id_rs2`.
- Forwarding (combinational, from the stored `ex_rs1`): `SEL_A` = 10 if `exmem_RegWrite` and `exmem_rd` != 0 and `exmem_rd` == `ex_rs1`. Otherwise 01 under the same condition on `memwb_*`. Otherwise 00.
  - `SEL_B` uses the same rule with `ex_rs2`.
  - EX/MEM has priority over MEM/WB.
  - When `ex_valid` = 0, both selects are forced to 00.
- Register x0 is never forwarded or bypassed.
- Load-use: `stall_id` = `ex_valid` & `ex_MemRead` & (`ex_rd` != 0) & `id_valid` & (`ex_rd` == `id_rs1` | `ex_rd` == `id_rs2`).
  - When asserted and neither `flush` nor `hold` is active, a bubble is inserted.
  - On the next cycle the load sits in MEM and the held consumer re-enters normally.
  - `flush` overrides: the bubble is inserted via flush and `stall_id` is still reported (IF/ID flush logic dominates upstream).

## Timing
- Reset values: all registered outputs 0. `SEL_A`/`SEL_B` = 00 and `stall_id` = 0 follow, since `ex_valid` = 0.
- Latency: ID to EX outputs is exactly 1 cycle.
- `SEL_*` and `stall_id` are valid in the same cycle as their inputs, with no added latency.
- `reset` asserted mid-operation clears the stage immediately and asynchronously. Deassertion takes effect at the next clock edge.
- Back-to-back loads and dependent instructions: exactly one bubble per load-use pair.
- Dependent non-load instructions: zero bubbles.

## Configuration
- `ID_EX_LOAD_USE_STALL_EN`
- Defined: hazard detection as above.
- Undefined:
  - `stall_id` is tied to 0 and no load-use bubbles are generated.
  - The compiler/scheduler guarantees a one-instruction gap after loads.
  - Forwarding and WB bypass are unchanged.

## Test plan
- Reset with `reset`=1 mid-run, `id_valid`=1 -> all EX outputs 0, `SEL_A`=`SEL_B`=00, `stall_id`=0; first edge after release loads the ID values.
- ADD x5 then ADD x6,x5,x5 -> second in EX with `exmem_rd`=5, `exmem_RegWrite`=1 -> `SEL_A`=`SEL_B`=10; same `rd` also in MEM/WB -> still 10.
- LW x7 in EX, `id_rs2`=7 -> `stall_id`=1, next cycle `ex_valid`=0; following cycle the consumer is in EX with `SEL_B`=01 once the load reaches WB via MEM/WB.
- `memwb_rd`=3, `wb_data`=0xDEADBEEF, `id_rs1`=3, `id_A`=0x0 -> `A`=0xDEADBEEF after the edge; repeated with rd=0 -> `A`=0x0.
- `flush`=1 and `hold`=1 together -> bubble loaded. `hold` alone for 3 cycles -> outputs unchanged.
- `ID_EX_LOAD_USE_STALL_EN` undefined, load-use pair -> `stall_id`=0, no bubble, consumer enters EX next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU execute stage, with
//   same-cycle WB bypass at capture, EX-side forwarding selects and load-use hazard detection.
// Latency: ID -> EX outputs exactly 1 cycle; SEL_A/SEL_B/stall_id are combinational (0 cycles).
// Backpressure: hold freezes every register; stall_id asks IF/ID to hold while a bubble is inserted.
//
// Ports:
//   clk, reset (async, active-high), flush, hold
//   id_*            : decoded instruction from ID (operands, indices, control)
//   exmem_*, memwb_*: destination info of the instructions in MEM and WB, wb_data = WB result
//   A, B, immediate, ALUop, ALUsrc, ex_* : registered EX-stage contents
//   SEL_A, SEL_B    : operand forwarding selects (00 reg, 01 writeback, 10 EX/MEM result)
//   stall_id        : load-use hazard, IF/ID must hold
//
// Build option: define ID_EX_LOAD_USE_STALL_EN to enable load-use hazard detection.
// Without it stall_id is tied low and the scheduler must leave a gap after every load.

module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            hold,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_A,
  input  logic [XLEN-1:0] id_B,
  input  logic [XLEN-1:0] id_immediate,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [3:0]      id_ALUop,
  input  logic            id_ALUsrc,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_RegWrite,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_RegWrite,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [XLEN-1:0] immediate,
  output logic [3:0]      ALUop,
  output logic            ALUsrc,
  output logic [1:0]      SEL_A,
  output logic [1:0]      SEL_B,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_valid,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            stall_id
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [3:0]      aluop_q, aluop_d;
  logic            alusrc_q, alusrc_d;
  logic [RW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;

  logic            wb_hit_rs1, wb_hit_rs2;
  logic            exm_fwd_a, exm_fwd_b, wb_fwd_a, wb_fwd_b;

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in EX has no data until it leaves MEM, so a
  // dependent instruction in ID must wait one cycle.
  // ---------------------------------------------------------------------------
`ifdef ID_EX_LOAD_USE_STALL_EN
  assign stall_id = valid_q && memread_q && (rd_q != '0) && id_valid &&
                    ((rd_q == id_rs1) || (rd_q == id_rs2));
`else
  assign stall_id = 1'b0;
`endif

  // WB result written this cycle is not yet visible in the register file
  // read data, so pick it up directly while capturing. x0 is never bypassed.
  assign wb_hit_rs1 = memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == id_rs1);
  assign wb_hit_rs2 = memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == id_rs2);

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;

    // flush beats hold; hold beats the load-use bubble.
    if (flush || (!hold && stall_id)) begin
      a_d        = '0;
      b_d        = '0;
      imm_d      = '0;
      aluop_d    = 4'b0000;
      alusrc_d   = 1'b0;
      rd_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (!hold) begin
      a_d        = wb_hit_rs1 ? wb_data : id_A;
      b_d        = wb_hit_rs2 ? wb_data : id_B;
      imm_d      = id_immediate;
      aluop_d    = id_ALUop;
      alusrc_d   = id_ALUsrc;
      rd_d       = id_rd;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      valid_d    = id_valid;
      regwrite_d = id_RegWrite;
      memread_d  = id_MemRead;
      memwrite_d = id_MemWrite;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluop_q    <= 4'b0000;
      alusrc_q   <= 1'b0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects for the instruction in EX. The newer EX/MEM result wins
  // over MEM/WB; an empty EX slot never forwards.
  // ---------------------------------------------------------------------------
  assign exm_fwd_a = exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == rs1_q);
  assign exm_fwd_b = exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == rs2_q);
  assign wb_fwd_a  = memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == rs1_q);
  assign wb_fwd_b  = memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == rs2_q);

  always_comb begin
    SEL_A = SEL_REG;
    SEL_B = SEL_REG;
    if (valid_q) begin
      if (exm_fwd_a)     SEL_A = SEL_EX;
      else if (wb_fwd_a) SEL_A = SEL_WB;
      if (exm_fwd_b)     SEL_B = SEL_EX;
      else if (wb_fwd_b) SEL_B = SEL_WB;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign immediate   = imm_q;
  assign ALUop       = aluop_q;
  assign ALUsrc      = alusrc_q;
  assign ex_rd       = rd_q;
  assign ex_valid    = valid_q;
  assign ex_RegWrite = regwrite_q;
  assign ex_MemRead  = memread_q;
  assign ex_MemWrite = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, WB bypass, load-use,
// flush/hold priority. Expectations follow the ID_EX_LOAD_USE_STALL_EN build option.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, hold, id_valid;
  logic [31:0] id_A, id_B, id_immediate, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [3:0]  id_ALUop;
  logic        id_ALUsrc, id_RegWrite, id_MemRead, id_MemWrite;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [31:0] A, B, immediate;
  logic [3:0]  ALUop;
  logic        ALUsrc;
  logic [1:0]  SEL_A, SEL_B;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, stall_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_A(id_A), .id_B(id_B), .id_immediate(id_immediate),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ALUop(id_ALUop), .id_ALUsrc(id_ALUsrc), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite),
    .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite), .wb_data(wb_data),
    .A(A), .B(B), .immediate(immediate), .ALUop(ALUop), .ALUsrc(ALUsrc),
    .SEL_A(SEL_A), .SEL_B(SEL_B), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .stall_id(stall_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [3:0] op, input logic src,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v;   id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_A = a;       id_B = b;     id_immediate = imm;
    id_ALUop = op;  id_ALUsrc = src;
    id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
  endtask

  task automatic set_hz(input logic [4:0] exrd, input logic exrw,
                        input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbd);
    exmem_rd = exrd; exmem_RegWrite = exrw;
    memwb_rd = wbrd; memwb_RegWrite = wbrw; wb_data = wbd;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_hz(5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    #3;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_A", A, 32'h0);
    chk("rst_sel", {SEL_A, SEL_B}, 4'b0000);
    chk("rst_stall", stall_id, 1'b0);

    // ADD x5, x1, x2
    reset = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_rd", ex_rd, 5'd5);
    chk("add_A", A, 32'h11);
    chk("add_B", B, 32'h22);
    chk("add_op", ALUop, 4'd2);
    chk("add_ctl", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b1100);

    // Asynchronous reset mid-cycle, with a live instruction in ID
    reset = 1'b1;
    #1;
    chk("arst_ctl", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b0000);
    chk("arst_A", A, 32'h0);
    chk("arst_rd", ex_rd, 5'd0);
    chk("arst_op", ALUop, 4'd0);
    chk("arst_stall", stall_id, 1'b0);
    #1;
    reset = 1'b0;
    // ADD x6, x5, x5 loads on the first edge after release
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 32'h33, 32'h44, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rel_rd", ex_rd, 5'd6);
    chk("rel_A", A, 32'h33);
    chk("rel_valid", ex_valid, 1'b1);

    // Forwarding for x6 = x5 + x5
    set_hz(5'd5, 1'b1, 5'd0, 1'b0, 32'h0);
    #1;
    chk("fwd_ex", {SEL_A, SEL_B}, 4'b1010);
    set_hz(5'd5, 1'b1, 5'd5, 1'b1, 32'h0);
    #1;
    chk("fwd_ex_prio", {SEL_A, SEL_B}, 4'b1010);
    set_hz(5'd5, 1'b0, 5'd5, 1'b1, 32'h0);
    #1;
    chk("fwd_wb", {SEL_A, SEL_B}, 4'b0101);
    set_hz(5'd5, 1'b1, 5'd2, 1'b1, 32'h0);
    #1;
    chk("fwd_none", {SEL_A, SEL_B}, 4'b1010);
    set_hz(5'd9, 1'b1, 5'd2, 1'b1, 32'h0);
    #1;
    chk("fwd_nomatch", {SEL_A, SEL_B}, 4'b0000);

    // WB bypass at capture: x3 written back while being read in ID
    set_hz(5'd0, 1'b0, 5'd3, 1'b1, 32'hDEADBEEF);
    set_id(1'b1, 5'd3, 5'd4, 5'd8, 32'h0, 32'h55, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("byp_A", A, 32'hDEADBEEF);
    chk("byp_B", B, 32'h55);
    // Same with x0: never bypassed
    set_hz(5'd0, 1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
    set_id(1'b1, 5'd0, 5'd4, 5'd8, 32'h0, 32'h55, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("byp_x0_A", A, 32'h0);

    // LW x7, 4(x1)
    set_hz(5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lw_ctl", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b1110);
    chk("lw_imm", immediate, 32'h4);
    chk("lw_src", ALUsrc, 1'b1);
    // Consumer x9 = x2 op x7 arrives in ID
    set_id(1'b1, 5'd2, 5'd7, 5'd9, 32'h66, 32'h77, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef ID_EX_LOAD_USE_STALL_EN
    chk("lu_stall", stall_id, 1'b1);
    tick();
    chk("lu_bubble", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b0000);
    chk("lu_bubble_rd", ex_rd, 5'd0);
    chk("lu_stall_clr", stall_id, 1'b0);
    set_hz(5'd7, 1'b1, 5'd0, 1'b0, 32'h0);
    tick();
    set_hz(5'd0, 1'b0, 5'd7, 1'b1, 32'h1234);
    #1;
    chk("lu_cons_rd", ex_rd, 5'd9);
    chk("lu_cons_valid", ex_valid, 1'b1);
    chk("lu_cons_B", B, 32'h77);
    chk("lu_cons_sel", {SEL_A, SEL_B}, 4'b0001);
`else
    chk("lu_nostall", stall_id, 1'b0);
    tick();
    chk("lu_cons_rd", ex_rd, 5'd9);
    chk("lu_cons_valid", ex_valid, 1'b1);
    set_hz(5'd7, 1'b1, 5'd0, 1'b0, 32'h0);
    #1;
    chk("lu_cons_sel", {SEL_A, SEL_B}, 4'b0010);
`endif

    // flush together with hold loads a bubble
    set_hz(5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'h12, 32'h34, 32'h8, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1; hold = 1'b1;
    tick();
    flush = 1'b0; hold = 1'b0;
    chk("flush_ctl", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b0000);
    chk("flush_rd", ex_rd, 5'd0);
    chk("flush_op", ALUop, 4'd0);
    chk("flush_A", A, 32'h0);

    // hold for 3 cycles keeps a stored store instruction
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'hAA, 32'hBB, 32'hC, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("st_rd", ex_rd, 5'd11);
    hold = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd12, 32'h1, 32'h2, 32'h3, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk("hold_rd", ex_rd, 5'd11);
    chk("hold_A", A, 32'hAA);
    chk("hold_imm", immediate, 32'hC);
    chk("hold_op", ALUop, 4'd5);
    chk("hold_ctl", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite}, 4'b1001);
    hold = 1'b0;

    // Invalid slot in EX: selects forced to register even on an index match
    set_id(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_hz(5'd5, 1'b1, 5'd5, 1'b1, 32'h0);
    #1;
    chk("inv_sel", {SEL_A, SEL_B}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
